// File: rtl/block_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : block_dispatcher
// Brief    : Splits a kernel launch into blocks and hands them to free cores.
// Revision : 1.0
// ============================================================================
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  start,
    input  logic [7:0]                                            thread_count,
    input  logic [NUM_CORES-1:0]                                  core_done,
    output logic [NUM_CORES-1:0]                                  core_start,
    output logic [NUM_CORES-1:0]                                  core_reset,
    output logic [NUM_CORES-1:0][7:0]                             core_block_id,
    output logic [NUM_CORES-1:0][$clog2(THREADS_PER_BLOCK):0]     core_thread_count,
    output logic                                                  done
);

    localparam int c_TPB_LOG2 = $clog2(THREADS_PER_BLOCK);
    localparam int c_CW       = c_TPB_LOG2 + 1;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_LAUNCH   = 2'd1;
    localparam logic [1:0] c_DISPATCH = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    logic [1:0]                       r_state;
    logic [8:0]                       r_total_blocks;
    logic [8:0]                       r_blocks_dispatched;
    logic [8:0]                       r_blocks_done;
    logic [7:0]                       r_thread_count;
    logic [NUM_CORES-1:0]             r_busy;
    logic [NUM_CORES-1:0]             r_core_start;
    logic [NUM_CORES-1:0]             r_core_reset;
    logic [NUM_CORES-1:0][7:0]        r_core_block_id;
    logic [NUM_CORES-1:0][c_CW-1:0]   r_core_thread_count;
    logic                             r_done;

    logic [8:0]                       w_total;
    logic [15:0]                      w_offset;
    logic [15:0]                      w_remaining;
    logic [c_CW-1:0]                  w_chunk;
    logic [NUM_CORES-1:0]             w_complete;
    logic [NUM_CORES-1:0]             w_grant;
    logic [NUM_CORES-1:0]             w_assign;
    logic [8:0]                       w_done_cnt;
    logic                             w_found;
    logic                             w_dispatch;

    assign w_total     = ({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> c_TPB_LOG2;
    assign w_offset    = {7'd0, r_blocks_dispatched} << c_TPB_LOG2;
    assign w_remaining = {8'd0, r_thread_count} - w_offset;
    assign w_chunk     = (w_remaining >= 16'(THREADS_PER_BLOCK)) ? c_CW'(THREADS_PER_BLOCK)
                                                                : w_remaining[c_CW-1:0];
    // Only cores that are actually running a block may complete one.
    assign w_complete  = r_busy & core_done;

    // A core still in its recycle reset is not yet eligible for a new block.
    always_comb begin
        w_grant    = '0;
        w_found    = 1'b0;
        w_done_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_done_cnt = w_done_cnt + {8'd0, w_complete[i]};
            if (!w_found && !r_busy[i] && !r_core_reset[i]) begin
                w_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    assign w_dispatch = (r_blocks_dispatched < r_total_blocks) && w_found;
    assign w_assign   = w_grant & {NUM_CORES{w_dispatch}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state             <= c_IDLE;
            r_total_blocks      <= '0;
            r_blocks_dispatched <= '0;
            r_blocks_done       <= '0;
            r_thread_count      <= '0;
            r_busy              <= '0;
            r_core_start        <= '0;
            r_core_reset        <= '0;
            r_core_block_id     <= '0;
            r_core_thread_count <= '0;
            r_done              <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_core_start <= '0;
                    if (start) begin
                        r_total_blocks      <= w_total;
                        r_thread_count      <= thread_count;
                        r_blocks_dispatched <= '0;
                        r_blocks_done       <= '0;
                        r_busy              <= '0;
                        r_core_reset        <= '1;
                        r_state             <= c_LAUNCH;
                    end else begin
                        r_core_reset <= '0;
                    end
                end
                c_LAUNCH: begin
                    r_core_reset <= '0;
                    r_state      <= c_DISPATCH;
                end
                c_DISPATCH: begin
                    if (r_blocks_done == r_total_blocks) begin
                        r_state      <= c_DONE;
                        r_done       <= 1'b1;
                        r_core_start <= '0;
                        r_core_reset <= '0;
                        r_busy       <= '0;
                    end else begin
                        r_core_reset  <= w_complete;
                        r_blocks_done <= r_blocks_done + w_done_cnt;
                        r_busy        <= (r_busy & ~w_complete) | w_assign;
                        r_core_start  <= (r_core_start & ~w_complete) | w_assign;
                        if (w_dispatch) begin
                            r_blocks_dispatched <= r_blocks_dispatched + 9'd1;
                        end
                        for (int i = 0; i < NUM_CORES; i++) begin
                            if (w_assign[i]) begin
                                r_core_block_id[i]     <= r_blocks_dispatched[7:0];
                                r_core_thread_count[i] <= w_chunk;
                            end
                        end
                    end
                end
                c_DONE: begin
                    r_core_start <= '0;
                    r_core_reset <= '0;
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign core_start        = r_core_start;
    assign core_reset        = r_core_reset;
    assign core_block_id     = r_core_block_id;
    assign core_thread_count = r_core_thread_count;
    assign done              = r_done;

endmodule
`default_nettype wire

// File: tb/tb_block_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_dispatcher
// Brief    : Directed self-checking bench for block_dispatcher (2 cores, TPB=4).
// Revision : 1.0
// ============================================================================
module tb_block_dispatcher;

    logic             clk;
    logic             reset;
    logic             start;
    logic [7:0]       thread_count;
    logic [1:0]       core_done;
    logic [1:0]       core_start;
    logic [1:0]       core_reset;
    logic [1:0][7:0]  core_block_id;
    logic [1:0][2:0]  core_thread_count;
    logic             done;

    int total = 0;
    int bad   = 0;

    block_dispatcher #(
        .NUM_CORES        (2),
        .THREADS_PER_BLOCK(4)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .thread_count     (thread_count),
        .core_done        (core_done),
        .core_start       (core_start),
        .core_reset       (core_reset),
        .core_block_id    (core_block_id),
        .core_thread_count(core_thread_count),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        thread_count = 8'd0;
        core_done    = 2'b00;
        tick();
        tick();
        check("rst_start", 32'(core_start), 32'h0);
        check("rst_creset", 32'(core_reset), 32'h0);
        check("rst_bid", 32'(core_block_id), 32'h0);
        check("rst_tcnt", 32'(core_thread_count), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset = 1'b1;
        tick();

        // basic split: 8 threads -> two blocks of 4
        start = 1'b1; thread_count = 8'd8;
        tick(); // E0
        check("b_e0_creset", 32'(core_reset), 32'h3);
        check("b_e0_start", 32'(core_start), 32'h0);
        tick(); // E1
        check("b_e1_creset", 32'(core_reset), 32'h0);
        check("b_e1_start", 32'(core_start), 32'h0);
        tick(); // E2
        check("b_e2_start", 32'(core_start), 32'h1);
        check("b_e2_bid0", 32'(core_block_id[0]), 32'd0);
        check("b_e2_cnt0", 32'(core_thread_count[0]), 32'd4);
        tick(); // E3
        check("b_e3_start", 32'(core_start), 32'h3);
        check("b_e3_bid1", 32'(core_block_id[1]), 32'd1);
        check("b_e3_cnt1", 32'(core_thread_count[1]), 32'd4);
        core_done = 2'b11;
        tick(); // E4
        core_done = 2'b00;
        check("b_e4_start", 32'(core_start), 32'h0);
        check("b_e4_creset", 32'(core_reset), 32'h3);
        check("b_e4_done", 32'(done), 32'h0);
        tick(); // E5
        check("b_e5_done", 32'(done), 32'h1);
        check("b_e5_creset", 32'(core_reset), 32'h0);
        check("b_e5_bid_hold", 32'(core_block_id[1]), 32'd1);
        start = 1'b0;
        tick();
        check("b_idle_done", 32'(done), 32'h0);
        tick();

        // partial last block: 10 threads -> 4,4,2
        start = 1'b1; thread_count = 8'd10;
        tick(); tick(); tick(); // E2
        check("p_e2_cnt0", 32'(core_thread_count[0]), 32'd4);
        tick(); // E3
        check("p_e3_start", 32'(core_start), 32'h3);
        check("p_e3_cnt1", 32'(core_thread_count[1]), 32'd4);
        core_done = 2'b10;
        tick(); // E4
        core_done = 2'b00;
        check("p_e4_start", 32'(core_start), 32'h1);
        check("p_e4_creset", 32'(core_reset), 32'h2);
        tick(); // E5
        check("p_e5_creset", 32'(core_reset), 32'h0);
        check("p_e5_start", 32'(core_start), 32'h1);
        tick(); // E6
        check("p_e6_start", 32'(core_start), 32'h3);
        check("p_e6_bid1", 32'(core_block_id[1]), 32'd2);
        check("p_e6_cnt1", 32'(core_thread_count[1]), 32'd2);
        core_done = 2'b11;
        tick(); // E7
        core_done = 2'b00;
        check("p_e7_done", 32'(done), 32'h0);
        tick(); // E8
        check("p_e8_done", 32'(done), 32'h1);
        start = 1'b0;
        tick();
        tick();

        // zero threads
        start = 1'b1; thread_count = 8'd0;
        tick(); // E0
        check("z_e0_start", 32'(core_start), 32'h0);
        tick(); // E1
        check("z_e1_done", 32'(done), 32'h0);
        check("z_e1_start", 32'(core_start), 32'h0);
        tick(); // E2
        check("z_e2_done", 32'(done), 32'h1);
        check("z_e2_start", 32'(core_start), 32'h0);
        tick();
        check("z_hold_start", 32'(core_start), 32'h0);
        start = 1'b0;
        tick();
        check("z_idle_done", 32'(done), 32'h0);
        tick();

        // simultaneous completion: 16 threads -> 4 blocks
        start = 1'b1; thread_count = 8'd16;
        tick(); tick(); tick(); tick(); // E3
        check("s_e3_start", 32'(core_start), 32'h3);
        core_done = 2'b11;
        tick(); // E4
        core_done = 2'b00;
        check("s_e4_start", 32'(core_start), 32'h0);
        check("s_e4_creset", 32'(core_reset), 32'h3);
        tick(); // E5
        check("s_e5_start", 32'(core_start), 32'h0);
        tick(); // E6
        check("s_e6_start", 32'(core_start), 32'h1);
        check("s_e6_bid0", 32'(core_block_id[0]), 32'd2);
        tick(); // E7
        check("s_e7_start", 32'(core_start), 32'h3);
        check("s_e7_bid1", 32'(core_block_id[1]), 32'd3);
        core_done = 2'b11;
        tick(); // E8
        core_done = 2'b00;
        tick(); // E9
        check("s_e9_done", 32'(done), 32'h1);
        start = 1'b0;
        tick();
        tick();

        // asynchronous reset while blocks are in flight
        start = 1'b1; thread_count = 8'd8;
        tick(); tick(); tick(); tick(); // E3
        check("r_e3_start", 32'(core_start), 32'h3);
        #2 reset = 1'b0;
        #1;
        check("r_async_start", 32'(core_start), 32'h0);
        check("r_async_bid", 32'(core_block_id), 32'h0);
        check("r_async_tcnt", 32'(core_thread_count), 32'h0);
        check("r_async_done", 32'(done), 32'h0);
        tick();
        check("r_held_creset", 32'(core_reset), 32'h0);
        reset = 1'b1;
        tick(); // relaunch E0
        check("r_e0_creset", 32'(core_reset), 32'h3);
        tick(); tick(); // E2
        check("r_e2_start", 32'(core_start), 32'h1);
        check("r_e2_cnt0", 32'(core_thread_count[0]), 32'd4);
        tick(); // E3
        check("r_e3b_bid1", 32'(core_block_id[1]), 32'd1);
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        tick();
        check("r_done", 32'(done), 32'h1);
        start = 1'b0;
        tick();
        tick();

        // back-to-back kernels, first with a single block
        start = 1'b1; thread_count = 8'd4;
        tick(); tick(); tick(); // E2
        check("k1_e2_start", 32'(core_start), 32'h1);
        tick(); // E3
        check("k1_e3_start", 32'(core_start), 32'h1);
        core_done = 2'b01;
        tick(); // E4
        core_done = 2'b00;
        check("k1_e4_creset", 32'(core_reset), 32'h1);
        tick(); // E5
        check("k1_e5_done", 32'(done), 32'h1);
        start = 1'b0;
        tick();
        check("k1_idle_done", 32'(done), 32'h0);
        // second kernel: 12 threads, spurious done on idle core1 during launch
        core_done = 2'b10;
        start = 1'b1; thread_count = 8'd12;
        tick(); tick(); tick(); // E2
        core_done = 2'b00;
        check("k2_e2_start", 32'(core_start), 32'h1);
        check("k2_e2_bid0", 32'(core_block_id[0]), 32'd0);
        tick(); // E3
        check("k2_e3_start", 32'(core_start), 32'h3);
        check("k2_e3_bid1", 32'(core_block_id[1]), 32'd1);
        core_done = 2'b01;
        tick(); // E4
        core_done = 2'b00;
        check("k2_e4_start", 32'(core_start), 32'h2);
        tick(); // E5
        check("k2_e5_done", 32'(done), 32'h0);
        tick(); // E6
        check("k2_e6_start", 32'(core_start), 32'h3);
        check("k2_e6_bid0", 32'(core_block_id[0]), 32'd2);
        check("k2_e6_cnt0", 32'(core_thread_count[0]), 32'd4);
        core_done = 2'b11;
        tick(); // E7
        core_done = 2'b00;
        check("k2_e7_done", 32'(done), 32'h0);
        tick(); // E8
        check("k2_e8_done", 32'(done), 32'h1);
        start = 1'b0;
        tick();
        check("k2_idle_done", 32'(done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
